// File: rtl/connect4_pkg.sv
// connect4_pkg: shared states, status codes, board size and LED indices for the 4x4 Connect-4 core
package connect4_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  typedef enum logic [1:0] {IDLE = 2'b00, PLACE = 2'b01, CHECK = 2'b10, OVER = 2'b11} state_e;
  typedef enum logic [1:0] {PLAYING = 2'b00, P1_WIN = 2'b01, P2_WIN = 2'b10, TIE = 2'b11} status_e;
  localparam int LED_P1_TURN = 0;
  localparam int LED_P2_TURN = 1;
  localparam int LED_P1_WIN = 2;
  localparam int LED_P2_WIN = 3;
  localparam int LED_TIE = 4;
  localparam int LED_REJECT = 5;
  localparam int LED_OVER = 6;
endpackage

// File: rtl/connect4_win_check.sv
// connect4_win_check: flags a completed row/column in a player bitboard; diagonals only with DIAG_WIN_EN
module connect4_win_check
  import connect4_pkg::*;
(
  input  logic [15:0] board_i,
  output logic        win_o
);
  logic [ROWS-1:0] row_w;
  logic [COLS-1:0] col_w;
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign row_w[r] = &board_i[r*COLS +: COLS];
  end
  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign col_w[c] = &{board_i[c], board_i[c+4], board_i[c+8], board_i[c+12]};
  end
`ifdef DIAG_WIN_EN
  assign win_o = |row_w | |col_w | &{board_i[0], board_i[5], board_i[10], board_i[15]}
               | &{board_i[3], board_i[6], board_i[9], board_i[12]};
`else
  assign win_o = |row_w | |col_w;
`endif
endmodule

// File: rtl/fsm_col_sel_circuit.sv
// fsm_col_sel_circuit: 4x4 Connect-4 move FSM (drop, win/tie check, turn change); DIAG_WIN_EN adds diagonal wins
module fsm_col_sel_circuit
  import connect4_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  in_column,
  output logic [15:0] out_gameboard,
  output logic [15:0] out_players_cells,
  output logic [1:0]  out_game_status,
  output logic [1:0]  current_state,
  output logic        playerTurn,
  output logic [4:0]  column_calc,
  output logic [6:0]  LEDs,
  output logic [2:0]  counter_0,
  output logic [2:0]  counter_1,
  output logic [2:0]  counter_2,
  output logic [2:0]  counter_3
);
  logic [1:0]  state_q, state_d, status_q, col_idx;
  logic [15:0] board_q, cells_q, mover;
  logic [4:0]  calc_q;
  logic [2:0]  cnt_q [COLS];
  logic [2:0]  sel_cnt;
  logic [3:0]  sel;
  logic        turn_q, rej_q, en_q, en_rise, one_hot, win;
  assign en_rise = enable & ~en_q;
  assign sel = ~in_column;
  assign one_hot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign col_idx = {sel[3] | sel[2], sel[3] | sel[1]};
  assign sel_cnt = cnt_q[col_idx];
  assign mover = board_q & (turn_q ? cells_q : ~cells_q);
  connect4_win_check u_win (.board_i(mover), .win_o(win));
  always_comb begin
    state_d = state_q == IDLE  ? ((en_rise && one_hot && !sel_cnt[2]) ? PLACE : IDLE) :
              state_q == PLACE ? CHECK :
              state_q == CHECK ? ((win || &board_q) ? OVER : IDLE) : OVER;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      board_q  <= '0;
      cells_q  <= '0;
      status_q <= PLAYING;
      turn_q   <= 1'b0;
      calc_q   <= '0;
      rej_q    <= 1'b0;
      en_q     <= 1'b0;
      cnt_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      en_q    <= enable;
      case (state_q)
        IDLE: if (en_rise) begin
          if (one_hot) calc_q <= {sel_cnt, col_idx};
          rej_q <= !(one_hot && !sel_cnt[2]);
        end
        PLACE: begin
          board_q[calc_q[3:0]] <= 1'b1;
          cells_q[calc_q[3:0]] <= turn_q;
          cnt_q[calc_q[1:0]]   <= cnt_q[calc_q[1:0]] + 3'd1;
        end
        CHECK: begin
          if (win) status_q <= turn_q ? P2_WIN : P1_WIN;
          else if (&board_q) status_q <= TIE;
          else turn_q <= ~turn_q;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    LEDs = '0;
    LEDs[LED_P1_TURN] = state_q != OVER && !turn_q;
    LEDs[LED_P2_TURN] = state_q != OVER && turn_q;
    LEDs[LED_P1_WIN]  = status_q == P1_WIN;
    LEDs[LED_P2_WIN]  = status_q == P2_WIN;
    LEDs[LED_TIE]     = status_q == TIE;
    LEDs[LED_REJECT]  = rej_q;
    LEDs[LED_OVER]    = state_q == OVER;
  end
  assign out_gameboard     = board_q;
  assign out_players_cells = cells_q;
  assign out_game_status   = status_q;
  assign current_state     = state_q;
  assign playerTurn        = turn_q;
  assign column_calc       = calc_q;
  assign counter_0         = cnt_q[0];
  assign counter_1         = cnt_q[1];
  assign counter_2         = cnt_q[2];
  assign counter_3         = cnt_q[3];
endmodule

// File: tb/tb_fsm_col_sel_circuit.sv
// tb_fsm_col_sel_circuit: directed Connect-4 games with hand-computed board, status and LED values
module tb_fsm_col_sel_circuit;
  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [3:0]  in_column = 4'hF;
  logic [15:0] out_gameboard, out_players_cells;
  logic [1:0]  out_game_status, current_state;
  logic        playerTurn;
  logic [4:0]  column_calc;
  logic [6:0]  LEDs;
  logic [2:0]  counter_0, counter_1, counter_2, counter_3;
  int checks = 0, errors = 0;

  fsm_col_sel_circuit dut (
    .clk(clk), .reset(reset), .enable(enable), .in_column(in_column),
    .out_gameboard(out_gameboard), .out_players_cells(out_players_cells),
    .out_game_status(out_game_status), .current_state(current_state),
    .playerTurn(playerTurn), .column_calc(column_calc), .LEDs(LEDs),
    .counter_0(counter_0), .counter_1(counter_1), .counter_2(counter_2), .counter_3(counter_3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic req(input logic [3:0] v, input int hold);
    in_column = v;
    enable = 1'b1;
    repeat (hold) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic move(input int c, input int hold);
    req(~(4'(1) << c), hold);
  endtask

  task automatic play(input string s);
    for (int i = 0; i < s.len(); i++) move(int'(s[i]) - 48, 1);
  endtask

  task automatic chk_reset_state;
    chk("rst_board", out_gameboard, 16'h0000);
    chk("rst_cells", out_players_cells, 16'h0000);
    chk("rst_status", out_game_status, 2'b00);
    chk("rst_state", current_state, 2'b00);
    chk("rst_turn", playerTurn, 1'b0);
    chk("rst_leds", LEDs, 7'b0000001);
    chk("rst_calc", column_calc, 5'd0);
    chk("rst_cnt", {counter_3, counter_2, counter_1, counter_0}, 12'h000);
  endtask

  initial begin
    do_reset;
    chk_reset_state;
    // first move in column 3, stepping through the FSM latency
    in_column = 4'b0111;
    enable = 1'b1;
    @(negedge clk);
    chk("lat_place", current_state, 2'b01);
    chk("lat_board0", out_gameboard, 16'h0000);
    enable = 1'b0;
    @(negedge clk);
    chk("lat_check", current_state, 2'b10);
    chk("lat_board1", out_gameboard, 16'h0008);
    chk("lat_cnt3", counter_3, 3'd1);
    chk("lat_calc", column_calc, 5'b00011);
    @(negedge clk);
    chk("lat_idle", current_state, 2'b00);
    chk("lat_turn", playerTurn, 1'b1);
    chk("lat_leds", LEDs, 7'b0000010);
    @(negedge clk);
    play("333");
    chk("col3_board", out_gameboard, 16'h8888);
    chk("col3_cells", out_players_cells, 16'h8080);
    chk("col3_cnt", counter_3, 3'd4);
    move(3, 1);
    chk("full_calc", column_calc, 5'b10011);
    chk("full_rej", LEDs[5], 1'b1);
    chk("full_cnt", counter_3, 3'd4);
    chk("full_turn", playerTurn, 1'b0);
    chk("full_state", current_state, 2'b00);
    req(4'b1100, 1);
    chk("ill2_state", current_state, 2'b00);
    chk("ill2_rej", LEDs[5], 1'b1);
    chk("ill2_board", out_gameboard, 16'h8888);
    req(4'b1111, 1);
    chk("ill0_rej", LEDs[5], 1'b1);
    chk("ill0_calc", column_calc, 5'b10011);
    chk("ill0_turn", playerTurn, 1'b0);
    move(0, 1);
    chk("legal_rej", LEDs[5], 1'b0);
    chk("legal_board", out_gameboard, 16'h8889);
    chk("legal_turn", playerTurn, 1'b1);

    do_reset;
    play("0102020");
    chk("vert_status", out_game_status, 2'b01);
    chk("vert_state", current_state, 2'b11);
    chk("vert_cnt0", counter_0, 3'd4);
    chk("vert_board", out_gameboard, 16'h1157);
    chk("vert_cells", out_players_cells, 16'h0046);
    chk("vert_leds", LEDs, 7'b1000100);
    move(1, 1);
    chk("over_board", out_gameboard, 16'h1157);
    chk("over_state", current_state, 2'b11);
    do_reset;
    chk_reset_state;

    play("001122");
    move(0, 1);
    move(3, 5);
    chk("hold_cnt3", counter_3, 3'd1);
    chk("hold_board", out_gameboard, 16'h017F);
    chk("hold_turn", playerTurn, 1'b0);
    play("13");
    chk("horz_status", out_game_status, 2'b10);
    chk("horz_board", out_gameboard, 16'h03FF);
    chk("horz_cells", out_players_cells, 16'h00F8);
    chk("horz_leds", LEDs, 7'b1001000);

    do_reset;
    play("0222200013333111");
    chk("tie_status", out_game_status, 2'b11);
    chk("tie_state", current_state, 2'b11);
    chk("tie_board", out_gameboard, 16'hFFFF);
    chk("tie_cells", out_players_cells, 16'h3C3C);
    chk("tie_leds", LEDs, 7'b1010000);

    do_reset;
    play("01122323033");
    chk("diag_board", out_gameboard, 16'h8CFF);
`ifdef DIAG_WIN_EN
    chk("diag_status", out_game_status, 2'b01);
    chk("diag_state", current_state, 2'b11);
    move(0, 1);
    chk("diag_after", out_gameboard, 16'h8CFF);
`else
    chk("diag_status", out_game_status, 2'b00);
    chk("diag_state", current_state, 2'b00);
    chk("diag_turn", playerTurn, 1'b1);
    move(0, 1);
    chk("diag_after", out_gameboard, 16'h8DFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
